// File: rtl/gray_win3x3_gen.sv
// Raster pixel stream to 3x3 replicate-padded windows, one per pixel.
// Two line buffers supply the upper rows; a flush sequencer emits the last row after the frame.
module gray_win3x3_gen #(
  parameter int CW           = 10,
  parameter int DW           = 16,
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480
) (
  input  logic              i_Sys_clk,
  input  logic              i_Rst,
  input  logic              i_Sof,
  input  logic              i_Din_valid,
  input  logic [DW-1:0]     i_Din,
  output logic              o_Win_valid,
  output logic [9*DW-1:0]   o_Win,
  output logic [CW-1:0]     o_Win_row,
  output logic [CW-1:0]     o_Win_col,
  output logic              o_Frame_done,
  output logic              o_Err
);

  localparam int AW = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_COL = CW'(IMAGE_WIDTH - 1);
  localparam logic [CW-1:0] LAST_ROW = CW'(IMAGE_HEIGHT - 1);
  localparam logic [CW-1:0] NUM_ROWS = CW'(IMAGE_HEIGHT);

  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

  state_t          state, state_d;
  logic [CW-1:0]   in_col, in_row, col_d, row_d;
  logic            eol_pend, eol_d;

  logic            trig, rd_en, wr_en, kill, err_d;
  logic            t_first, t_eol, t_last, t_top_rep, t_bot_rep;
  logic [CW-1:0]   t_row, t_col;

  logic [DW-1:0]   lb1 [IMAGE_WIDTH];
  logic [DW-1:0]   lb2 [IMAGE_WIDTH];
  logic [AW-1:0]   addr;
  logic [DW-1:0]   lb1_q, lb2_q, din_q;

  logic            s1_vld, s1_first, s1_eol, s1_last, s1_top_rep, s1_bot_rep;
  logic [CW-1:0]   s1_row, s1_col;

  logic [3*DW-1:0] col_now, col_c1, col_c2;
  logic [9*DW-1:0] win_d;

  assign addr = in_col[AW-1:0];

  always_ff @(posedge i_Sys_clk) begin
    if (i_Rst) begin
      state    <= IDLE;
      in_col   <= '0;
      in_row   <= '0;
      eol_pend <= 1'b0;
    end else begin
      state    <= state_d;
      in_col   <= col_d;
      in_row   <= row_d;
      eol_pend <= eol_d;
    end
  end

  // Window centre lags input by one row and one column; EOL and flush steps
  // supply the missing right column and bottom row.
  always_comb begin
    state_d   = state;
    col_d     = in_col;
    row_d     = in_row;
    eol_d     = eol_pend;
    trig      = 1'b0;
    rd_en     = 1'b0;
    wr_en     = 1'b0;
    kill      = 1'b0;
    err_d     = 1'b0;
    t_first   = 1'b0;
    t_eol     = 1'b0;
    t_last    = 1'b0;
    t_top_rep = 1'b0;
    t_bot_rep = 1'b0;
    t_row     = '0;
    t_col     = '0;
    if (i_Sof) begin
      state_d = FILL;
      col_d   = '0;
      row_d   = '0;
      eol_d   = 1'b0;
      kill    = (state != IDLE);
      err_d   = (state != IDLE);
    end else begin
      case (state)
        IDLE: err_d = i_Din_valid;
        FILL: begin
          if (i_Din_valid) begin
            wr_en = 1'b1;
            if (in_col == LAST_COL) begin
              col_d   = '0;
              row_d   = CW'(1);
              state_d = RUN;
            end else begin
              col_d = in_col + 1'b1;
            end
          end
        end
        RUN: begin
          if (eol_pend) begin
            trig  = 1'b1;
            t_eol = 1'b1;
            t_row = in_row - CW'(2);
            t_col = LAST_COL;
            eol_d = 1'b0;
            err_d = i_Din_valid;
            if (in_row == NUM_ROWS) state_d = FLUSH;
          end else if (i_Din_valid) begin
            trig      = 1'b1;
            rd_en     = 1'b1;
            wr_en     = 1'b1;
            t_first   = (in_col == '0);
            t_top_rep = (in_row == CW'(1));
            t_row     = in_row - 1'b1;
            t_col     = in_col - 1'b1;
            if (in_col == LAST_COL) begin
              col_d = '0;
              row_d = in_row + 1'b1;
              eol_d = 1'b1;
            end else begin
              col_d = in_col + 1'b1;
            end
          end
        end
        FLUSH: begin
          trig  = 1'b1;
          err_d = i_Din_valid;
          t_row = LAST_ROW;
          if (eol_pend) begin
            t_eol   = 1'b1;
            t_last  = 1'b1;
            t_col   = LAST_COL;
            eol_d   = 1'b0;
            col_d   = '0;
            row_d   = '0;
            state_d = IDLE;
          end else begin
            rd_en     = 1'b1;
            t_bot_rep = 1'b1;
            t_first   = (in_col == '0);
            t_col     = in_col - 1'b1;
            if (in_col == LAST_COL) begin
              col_d = '0;
              eol_d = 1'b1;
            end else begin
              col_d = in_col + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Read-before-write line buffers; taps hold through an EOL step so column W
  // repeats column W-1.
  always_ff @(posedge i_Sys_clk) begin
    if (wr_en) begin
      lb1[addr] <= i_Din;
      lb2[addr] <= lb1[addr];
    end
    if (rd_en) begin
      lb1_q <= lb1[addr];
      lb2_q <= lb2[addr];
      din_q <= i_Din;
    end
  end

  always_ff @(posedge i_Sys_clk) begin
    if (i_Rst) begin
      s1_vld     <= 1'b0;
      s1_first   <= 1'b0;
      s1_eol     <= 1'b0;
      s1_last    <= 1'b0;
      s1_top_rep <= 1'b0;
      s1_bot_rep <= 1'b0;
      s1_row     <= '0;
      s1_col     <= '0;
    end else begin
      s1_vld   <= trig;
      s1_first <= t_first;
      s1_eol   <= t_eol;
      s1_last  <= t_last;
      s1_row   <= t_row;
      s1_col   <= t_col;
      if (rd_en) begin
        s1_top_rep <= t_top_rep;
        s1_bot_rep <= t_bot_rep;
      end
    end
  end

  assign col_now = {(s1_bot_rep ? lb1_q : din_q), lb1_q, (s1_top_rep ? lb1_q : lb2_q)};

  always_comb begin
    win_d = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      win_d[(3*i)*DW   +: DW] = col_c2[i*DW +: DW];
      win_d[(3*i+1)*DW +: DW] = col_c1[i*DW +: DW];
      win_d[(3*i+2)*DW +: DW] = col_now[i*DW +: DW];
    end
  end

  always_ff @(posedge i_Sys_clk) begin
    if (i_Rst) begin
      o_Win_valid  <= 1'b0;
      o_Win        <= '0;
      o_Win_row    <= '0;
      o_Win_col    <= '0;
      o_Frame_done <= 1'b0;
      o_Err        <= 1'b0;
      col_c1       <= '0;
      col_c2       <= '0;
    end else begin
      o_Win_valid  <= 1'b0;
      o_Frame_done <= 1'b0;
      o_Err        <= err_d;
      if (s1_vld && !kill) begin
        if (s1_first) begin
          col_c1 <= col_now;
          col_c2 <= col_now;
        end else begin
          o_Win_valid  <= 1'b1;
          o_Win        <= win_d;
          o_Win_row    <= s1_row;
          o_Win_col    <= s1_col;
          o_Frame_done <= s1_last;
          if (!s1_eol) begin
            col_c2 <= col_c1;
            col_c1 <= col_now;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_gray_win3x3_gen.sv
// Scoreboard bench for gray_win3x3_gen on a small 8x4 image.
module tb_gray_win3x3_gen;

  localparam int CW = 10;
  localparam int DW = 16;
  localparam int W  = 8;
  localparam int H  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              sof = 1'b0;
  logic              din_valid = 1'b0;
  logic [DW-1:0]     din = '0;
  logic              o_Win_valid;
  logic [9*DW-1:0]   o_Win;
  logic [CW-1:0]     o_Win_row, o_Win_col;
  logic              o_Frame_done, o_Err;

  gray_win3x3_gen #(.CW(CW), .DW(DW), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H)) dut (
    .i_Sys_clk   (clk),
    .i_Rst       (rst),
    .i_Sof       (sof),
    .i_Din_valid (din_valid),
    .i_Din       (din),
    .o_Win_valid (o_Win_valid),
    .o_Win       (o_Win),
    .o_Win_row   (o_Win_row),
    .o_Win_col   (o_Win_col),
    .o_Frame_done(o_Frame_done),
    .o_Err       (o_Err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9*DW-1:0] win;
    int              row;
    int              col;
    bit              last;
  } exp_t;

  exp_t            exp_q[$];
  logic [DW-1:0]   img [H][W];
  int              cyc = 0;
  int              n_checks = 0, n_fails = 0;
  int              err_cnt = 0, done_cnt = 0, win_cnt = 0;
  int              win00_cyc = 0, win17_cyc = 0, pix11_cyc = 0, pix27_cyc = 0;
  logic [9*DW-1:0] win00_val = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int clampi(input int v, input int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  task automatic push_range(input int from_idx, input int to_idx);
    for (int idx = from_idx; idx <= to_idx; idx++) begin
      exp_t e;
      e.row  = idx / W;
      e.col  = idx % W;
      e.last = (idx == W*H-1);
      e.win  = '0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          e.win[(3*i+j)*DW +: DW] = img[clampi(e.row+i-1, H-1)][clampi(e.col+j-1, W-1)];
      exp_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (o_Err) err_cnt++;
    if (o_Frame_done) done_cnt++;
    if (o_Frame_done && !o_Win_valid) begin
      n_checks++;
      n_fails++;
      $display("FAIL frame_done_alone: got o_Frame_done=1 with o_Win_valid=0, required no pulse");
    end
    if (o_Win_valid) begin
      win_cnt++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fails++;
        $display("FAIL unexpected_window: got row=%0d col=%0d, required no window", o_Win_row, o_Win_col);
      end else begin
        e = exp_q.pop_front();
        if (o_Win !== e.win || o_Win_row !== CW'(e.row) || o_Win_col !== CW'(e.col) || o_Frame_done !== e.last) begin
          n_fails++;
          $display("FAIL window: got row=%0d col=%0d done=%0b win=%h, required row=%0d col=%0d done=%0b win=%h",
                   o_Win_row, o_Win_col, o_Frame_done, o_Win, e.row, e.col, e.last, e.win);
        end
        if (e.row == 0 && e.col == 0) begin
          win00_cyc = cyc;
          win00_val = o_Win;
        end
        if (e.row == 1 && e.col == W-1) win17_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_sof();
    sof = 1'b1;
    tick();
    sof = 1'b0;
  endtask

  task automatic send_pixel(input int r, input int c);
    din_valid = 1'b1;
    din = img[r][c];
    if (r == 1 && c == 1) pix11_cyc = cyc;
    if (r == 2 && c == W-1) pix27_cyc = cyc;
    tick();
    din_valid = 1'b0;
    din = '0;
  endtask

  task automatic send_row(input int r, input int max_gap);
    for (int c = 0; c < W; c++) begin
      if (max_gap > 0) idle(int'($urandom_range(0, max_gap)));
      send_pixel(r, c);
    end
  endtask

  task automatic send_rows(input int r0, input int r1, input int max_gap);
    for (int r = r0; r <= r1; r++) begin
      send_row(r, max_gap);
      idle(1 + ((max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0));
    end
  endtask

  task automatic set_pattern(input int base);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = DW'(base + 16*r + c);
  endtask

  task automatic set_random();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = DW'($urandom);
  endtask

  task automatic check_int(input string name, input int got, input int req);
    n_checks++;
    if (got !== req) begin
      n_fails++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic test_reset();
    int e0, w0;
    rst = 1'b1;
    set_pattern(0);
    idle(3);
    n_checks++; if (o_Win_valid !== 1'b0)  begin n_fails++; $display("FAIL reset_valid: got %b, required 0", o_Win_valid); end
    n_checks++; if (o_Win !== '0)          begin n_fails++; $display("FAIL reset_win: got %h, required 0", o_Win); end
    n_checks++; if (o_Win_row !== '0)      begin n_fails++; $display("FAIL reset_row: got %0d, required 0", o_Win_row); end
    n_checks++; if (o_Win_col !== '0)      begin n_fails++; $display("FAIL reset_col: got %0d, required 0", o_Win_col); end
    n_checks++; if (o_Frame_done !== 1'b0) begin n_fails++; $display("FAIL reset_done: got %b, required 0", o_Frame_done); end
    n_checks++; if (o_Err !== 1'b0)        begin n_fails++; $display("FAIL reset_err: got %b, required 0", o_Err); end
    rst = 1'b0;
    idle(2);
    e0 = err_cnt;
    w0 = win_cnt;
    send_pixel(0, 0);
    idle(3);
    check_int("idle_pixel_err", err_cnt - e0, 1);
    check_int("idle_pixel_windows", win_cnt - w0, 0);
  endtask

  task automatic test_frame();
    int e0, d0, w0;
    logic [9*DW-1:0] exp00;
    int vals [9];
    vals = '{0, 0, 1, 0, 0, 1, 16, 16, 17};
    exp00 = '0;
    for (int k = 0; k < 9; k++) exp00[k*DW +: DW] = DW'(vals[k]);
    e0 = err_cnt; d0 = done_cnt; w0 = win_cnt;
    set_pattern(0);
    push_range(0, W*H-1);
    send_sof();
    idle(1);
    send_rows(0, H-1, 0);
    idle(20);
    check_int("frame_pending", exp_q.size(), 0);
    check_int("frame_windows", win_cnt - w0, W*H);
    check_int("frame_done_count", done_cnt - d0, 1);
    check_int("frame_err", err_cnt - e0, 0);
    n_checks++;
    if (win00_val !== exp00) begin
      n_fails++;
      $display("FAIL win00_value: got %h, required %h", win00_val, exp00);
    end
    check_int("latency_first", win00_cyc - pix11_cyc, 2);
    check_int("latency_eol", win17_cyc - (pix27_cyc + 1), 2);
  endtask

  task automatic test_back_to_back();
    int e0, d0, w0;
    e0 = err_cnt; d0 = done_cnt; w0 = win_cnt;
    set_pattern(32);
    push_range(0, W*H-1);
    send_sof();
    idle(1);
    send_row(0, 0);
    idle(1);
    send_row(1, 0);
    send_pixel(2, 0);
    idle(1);
    send_row(2, 0);
    idle(1);
    send_row(3, 0);
    idle(20);
    check_int("b2b_pending", exp_q.size(), 0);
    check_int("b2b_windows", win_cnt - w0, W*H);
    check_int("b2b_err", err_cnt - e0, 1);
    check_int("b2b_done", done_cnt - d0, 1);
  endtask

  task automatic test_sof_abort();
    int e0, d0, w0;
    e0 = err_cnt; d0 = done_cnt; w0 = win_cnt;
    set_pattern(64);
    push_range(0, W);
    send_sof();
    idle(1);
    send_row(0, 0);
    idle(1);
    send_row(1, 0);
    idle(1);
    send_pixel(2, 0);
    send_pixel(2, 1);
    idle(3);
    send_sof();
    idle(1);
    check_int("abort_err", err_cnt - e0, 1);
    check_int("abort_old_pending", exp_q.size(), 0);
    set_pattern(200);
    push_range(0, W*H-1);
    send_rows(0, H-1, 0);
    idle(20);
    check_int("abort_new_pending", exp_q.size(), 0);
    check_int("abort_windows", win_cnt - w0, W + 1 + W*H);
    check_int("abort_done", done_cnt - d0, 1);
    check_int("abort_err_total", err_cnt - e0, 1);
  endtask

  task automatic test_reset_flush();
    int e0, d0, w0;
    d0 = done_cnt; w0 = win_cnt;
    set_pattern(5);
    push_range(0, 3*W-1);
    send_sof();
    idle(1);
    send_rows(0, H-2, 0);
    send_row(H-1, 0);
    idle(2);
    rst = 1'b1;
    tick();
    n_checks++;
    if ({o_Win_valid, o_Win, o_Win_row, o_Win_col, o_Frame_done, o_Err} !== '0) begin
      n_fails++;
      $display("FAIL flush_reset_outputs: got valid=%b row=%0d col=%0d done=%b err=%b win=%h, required all 0",
               o_Win_valid, o_Win_row, o_Win_col, o_Frame_done, o_Err, o_Win);
    end
    rst = 1'b0;
    idle(20);
    check_int("flush_reset_pending", exp_q.size(), 0);
    check_int("flush_reset_windows", win_cnt - w0, 3*W);
    check_int("flush_reset_done", done_cnt - d0, 0);
    e0 = err_cnt; d0 = done_cnt; w0 = win_cnt;
    set_pattern(9);
    push_range(0, W*H-1);
    send_sof();
    idle(1);
    send_rows(0, H-1, 0);
    idle(20);
    check_int("after_reset_pending", exp_q.size(), 0);
    check_int("after_reset_windows", win_cnt - w0, W*H);
    check_int("after_reset_done", done_cnt - d0, 1);
    check_int("after_reset_err", err_cnt - e0, 0);
  endtask

  task automatic test_random_gaps();
    int e0, d0, w0;
    for (int f = 0; f < 3; f++) begin
      e0 = err_cnt; d0 = done_cnt; w0 = win_cnt;
      set_random();
      push_range(0, W*H-1);
      send_sof();
      idle(1);
      send_rows(0, H-1, 2);
      idle(W + 6);
      check_int("random_pending", exp_q.size(), 0);
      check_int("random_windows", win_cnt - w0, W*H);
      check_int("random_done", done_cnt - d0, 1);
      check_int("random_err", err_cnt - e0, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required self-termination");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_frame();
    test_back_to_back();
    test_sof_abort();
    test_reset_flush();
    test_random_gaps();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
